lsu_req_unit: RTL



---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_fifo.sv | 35 +++
 rtl/lsu_req_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, tag layout and lane helpers for lsu_req_unit (dword support under LSU_DWORD_EN)
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef struct packed {
    logic [2:0] offset;
    logic [1:0] size;
    logic       uns;
    logic       store;
    logic       cancelled;
  } tag_t;
  function automatic logic [7:0] strb_gen(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
`ifdef LSU_DWORD_EN
    m = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'hff;
`else
    m = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0f : 8'h00;
`endif
    return m << off;
  endfunction
  function automatic logic [63:0] wdata_rep(input logic [63:0] d, input logic [1:0] size);
    return size == SZ_B ? {8{d[7:0]}} : size == SZ_H ? {4{d[15:0]}} : size == SZ_W ? {2{d[31:0]}} : d;
  endfunction
  function automatic logic [63:0] load_ext(input logic [63:0] rdata, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] s;
    s = rdata >> {off, 3'b000};
    return size == SZ_B ? {{56{~uns & s[7]}}, s[7:0]} :
           size == SZ_H ? {{48{~uns & s[15]}}, s[15:0]} :
           size == SZ_W ? {{32{~uns & s[31]}}, s[31:0]} : s;
  endfunction
endpackage

// File: rtl/lsu_fifo.sv
// lsu_fifo: synchronous FIFO with occupancy count and single-cycle clear
module lsu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          do_pop;
  assign do_pop = pop && count != '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push && !clear) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/lsu_req_unit.sv
// lsu_req_unit: load/store request unit with req/addr_ok issue, in-order responses and flush; LSU_DWORD_EN enables 64-bit dword ops
module lsu_req_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic                op_store,
  input  logic [1:0]          op_size,
  input  logic                op_unsigned,
  input  logic [ADDR_W-1:0]   op_addr,
  input  logic [DATA_W-1:0]   op_wdata,
  output logic                op_excp,
  output logic [ADDR_W-1:0]   op_badv,
  input  logic                flush,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [1:0]          data_sram_size,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W/8-1:0] data_sram_wstrb,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  logic [DATA_W-1:0]   data_sram_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_is_store,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [3:0]          pending
);
  localparam int SW    = DATA_W / 8;
  localparam int OFF_W = $clog2(SW);
  localparam int TCW   = $clog2(OUTSTANDING + 1);
  typedef enum logic {IDLE, REQ} state_t;
  state_t            state;
  logic              mis, accept, addr_hs, cancel, req_uns;
  logic [3:0]        drop_cnt;
  tag_t              tag_in, tag_out;
  logic [TCW-1:0]    tag_cnt, rsp_cnt;
  logic [DATA_W:0]   rsp_in, rsp_out;
  assign mis = (op_size == SZ_H && op_addr[0]) || (op_size == SZ_W && |op_addr[1:0])
`ifdef LSU_DWORD_EN
    || (op_size == SZ_D && (DATA_W != 64 || |op_addr[2:0]));
`else
    || op_size == SZ_D;
`endif
  assign op_excp = op_valid && mis;
  assign op_badv = op_excp ? op_addr : '0;
  assign op_ready = state == IDLE && pending < 4'(OUTSTANDING) && !flush;
  assign accept = op_valid && op_ready && !mis;
  assign data_sram_req = state == REQ;
  assign addr_hs = data_sram_req && data_sram_addr_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      data_sram_wr    <= 1'b0;
      data_sram_size  <= '0;
      data_sram_addr  <= '0;
      data_sram_wstrb <= '0;
      data_sram_wdata <= '0;
      req_uns         <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        state           <= REQ;
        data_sram_wr    <= op_store;
        data_sram_size  <= op_size;
        data_sram_addr  <= op_addr;
        data_sram_wstrb <= op_store ? SW'(strb_gen(op_size, 3'(op_addr[OFF_W-1:0]))) : '0;
        data_sram_wdata <= DATA_W'(wdata_rep(64'(op_wdata), op_size));
        req_uns         <= op_unsigned;
      end
    end else if (addr_hs || flush) state <= IDLE;
  end
  assign tag_in = '{offset: 3'(data_sram_addr[OFF_W-1:0]), size: data_sram_size, uns: req_uns,
                    store: data_sram_wr, cancelled: flush};
  lsu_fifo #(.W($bits(tag_t)), .DEPTH(OUTSTANDING), .CW(TCW)) u_tag_fifo (
    .clk(clk), .reset(reset), .clear(1'b0), .push(addr_hs), .din(tag_in),
    .pop(data_sram_data_ok), .dout(tag_out), .count(tag_cnt)
  );
  // drop_cnt covers the tags that were already queued when a flush hit
  assign cancel = tag_out.cancelled || drop_cnt != '0 || flush;
  assign rsp_in = {tag_out.store, tag_out.store ? {DATA_W{1'b0}} :
                   DATA_W'(load_ext(64'(data_sram_rdata), tag_out.offset, tag_out.size, tag_out.uns))};
  lsu_fifo #(.W(DATA_W + 1), .DEPTH(OUTSTANDING), .CW(TCW)) u_rsp_fifo (
    .clk(clk), .reset(reset), .clear(flush), .push(data_sram_data_ok && !cancel), .din(rsp_in),
    .pop(rsp_valid && rsp_ready), .dout(rsp_out), .count(rsp_cnt)
  );
  assign rsp_valid = rsp_cnt != '0;
  assign rsp_is_store = rsp_valid && rsp_out[DATA_W];
  assign rsp_data = rsp_valid ? rsp_out[DATA_W-1:0] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      pending  <= 4'(tag_cnt) + 4'(addr_hs) - 4'(data_sram_data_ok);
      drop_cnt <= 4'(tag_cnt) - 4'(data_sram_data_ok);
    end else begin
      pending  <= pending + 4'(accept) - 4'(rsp_valid && rsp_ready) - 4'(data_sram_data_ok && cancel);
      drop_cnt <= drop_cnt - 4'(data_sram_data_ok && drop_cnt != '0);
    end
  end
endmodule
